// File: rtl/cond_exec_ctrl.sv
// Conditional-execution controller.
// Accepts one instruction at a time, tests its ARM condition field against
// the status register, and either launches the ALU (condition passed) or
// retires the instruction as skipped. The status register takes ALU flags on
// execute when the S bit is set, or direct MSR-style writes.
module cond_exec_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_cond,
    input  logic             issue_s,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [3:0]       alu_flags,
    output logic             alu_kill,
    input  logic             flush,
    input  logic             sr_wr_en,
    input  logic [3:0]       sr_wr_data,
    output logic [3:0]       sr,
    output logic             commit_valid,
    output logic             commit_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cond_q;
    logic       s_q;
    logic       cond_ok;

    // Next-cycle values for the registered pulse outputs and side effects.
    logic start_nx, kill_nx, commit_nx, commit_pass_nx;
    logic pass_inc, fail_inc, sr_from_alu;

    // ARM condition codes evaluated against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cf;
            4'h3:    return !cf;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cf && !z;
            4'h9:    return !cf || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // The condition sees the live status register during CHECK, so a write
    // landing on the accept edge is already visible.
    assign cond_ok     = cond_eval(cond_q, sr);
    assign issue_ready = (state == IDLE);

    // Next-state and next-output decode; flush overrides completion.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_nx       = state;
        start_nx       = 1'b0;
        kill_nx        = 1'b0;
        commit_nx      = 1'b0;
        commit_pass_nx = 1'b0;
        pass_inc       = 1'b0;
        fail_inc       = 1'b0;
        sr_from_alu    = 1'b0;
        case (state)
            IDLE: begin
                if (issue_valid) state_nx = CHECK;
            end
            CHECK: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (cond_ok) begin
                    state_nx = BUSY;
                    start_nx = 1'b1;
                end else begin
                    state_nx  = IDLE;
                    commit_nx = 1'b1;
                    fail_inc  = 1'b1;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nx = IDLE;
                    kill_nx  = 1'b1;
                end else if (alu_done) begin
                    state_nx       = IDLE;
                    commit_nx      = 1'b1;
                    commit_pass_nx = 1'b1;
                    pass_inc       = 1'b1;
                    sr_from_alu    = s_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register plus registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses <= so every register updates from pre-edge values.
        if (!rst_n) begin
            state        <= IDLE;
            alu_start    <= 1'b0;
            alu_kill     <= 1'b0;
            commit_valid <= 1'b0;
            commit_pass  <= 1'b0;
        end else begin
            state        <= state_nx;
            alu_start    <= start_nx;
            alu_kill     <= kill_nx;
            commit_valid <= commit_nx;
            commit_pass  <= commit_pass_nx;
        end
    end

    // Capture the offered instruction's condition and S bit on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_q <= 4'h0;
            s_q    <= 1'b0;
        end else if (issue_valid && issue_ready) begin
            cond_q <= issue_cond;
            s_q    <= issue_s;
        end
    end

    // Status register: ALU flag update beats a simultaneous direct write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= 4'h0;
        end else if (sr_from_alu) begin
            sr <= alu_flags;
        end else if (sr_wr_en) begin
            sr <= sr_wr_data;
        end
    end

    // Executed/skipped counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (pass_inc) pass_cnt <= pass_cnt + CNT_W'(1);
            if (fail_inc) fail_cnt <= fail_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Testbench for cond_exec_ctrl: directed scenarios plus randomized
// instructions, scored against a condition-table reference model.
module tb_cond_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_ready;
    logic [3:0] issue_cond = 4'h0;
    logic       issue_s = 1'b0;
    logic       alu_start;
    logic       alu_done = 1'b0;
    logic [3:0] alu_flags = 4'h0;
    logic       alu_kill;
    logic       flush = 1'b0;
    logic       sr_wr_en = 1'b0;
    logic [3:0] sr_wr_data = 4'h0;
    logic [3:0] sr;
    logic       commit_valid;
    logic       commit_pass;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;

    cond_exec_ctrl #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_cond   (issue_cond),
        .issue_s      (issue_s),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_flags    (alu_flags),
        .alu_kill     (alu_kill),
        .flush        (flush),
        .sr_wr_en     (sr_wr_en),
        .sr_wr_data   (sr_wr_data),
        .sr           (sr),
        .commit_valid (commit_valid),
        .commit_pass  (commit_pass),
        .pass_cnt     (pass_cnt),
        .fail_cnt     (fail_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pass;
        logic [3:0] sr;
        logic [7:0] pcnt;
        logic [7:0] fcnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model state.
    logic [3:0] ref_sr   = 4'h0;
    logic [7:0] ref_pass = 8'd0;
    logic [7:0] ref_fail = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition table written directly from the ARM condition definitions.
    function automatic bit cond_true(input int c, input logic [3:0] f);
        bit n, z, cf, v;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cf;
            3:  return !cf;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cf && !z;
            9:  return !cf || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Monitor: every retirement is matched to the oldest expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!commit_valid) begin
                if (commit_pass !== 1'b0) check("commit_pass_without_valid", commit_pass, 0);
            end else if (sb.size() == 0) begin
                check("unexpected_commit", commit_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("commit_pass", commit_pass, mon_e.pass);
                check("commit_sr", sr, mon_e.sr);
                check("commit_pass_cnt", pass_cnt, mon_e.pcnt);
                check("commit_fail_cnt", fail_cnt, mon_e.fcnt);
            end
        end
    end

    // Tasks start and end just after a falling edge.
    task automatic write_sr(input logic [3:0] d);
        sr_wr_en = 1'b1;
        sr_wr_data = d;
        @(negedge clk);
        sr_wr_en = 1'b0;
        ref_sr = d;
        check("sr_direct_write", sr, d);
    endtask

    // fl_mode: 0 none, 1 flush during CHECK, 2 flush with alu_done in BUSY.
    task automatic run_instr(input logic [3:0] cond, input logic s, input int lat,
                             input logic [3:0] flags, input int fl_mode,
                             input logic wr_done, input logic [3:0] wr_done_d,
                             input logic wr_acc, input logic [3:0] wr_acc_d);
        int   waits = 0;
        bit   ok;
        exp_t e;
        if (commit_valid) check("accept_in_commit_cycle", issue_ready, 1);
        while (!issue_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (!issue_ready) begin
            check("issue_ready_timeout", issue_ready, 1);
            return;
        end
        // IDLE cycle: alu_done and flush noise must be ignored here.
        issue_valid = 1'b1;
        issue_cond  = cond;
        issue_s     = s;
        alu_done    = 1'($urandom % 2);
        alu_flags   = 4'($urandom);
        flush       = 1'($urandom % 2);
        if (wr_acc) begin
            sr_wr_en   = 1'b1;
            sr_wr_data = wr_acc_d;
            ref_sr     = wr_acc_d;
        end
        ok = cond_true(int'(cond), ref_sr);
        @(negedge clk);
        // CHECK cycle: alu_done noise is still ignored.
        issue_valid = 1'b0;
        sr_wr_en    = 1'b0;
        flush       = 1'b0;
        alu_done    = 1'($urandom % 2);
        alu_flags   = 4'($urandom);
        check("sr_seen_in_check", sr, ref_sr);
        if (fl_mode == 1) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            alu_done = 1'b0;
            check("flush_check_no_start", alu_start, 0);
            check("flush_check_to_idle", issue_ready, 1);
            return;
        end
        if (!ok) begin
            ref_fail = ref_fail + 8'd1;
            e = '{pass: 1'b0, sr: ref_sr, pcnt: ref_pass, fcnt: ref_fail};
            sb.push_back(e);
            @(negedge clk);
            alu_done = 1'b0;
            check("skip_latency", commit_valid, 1);
            check("skip_no_start", alu_start, 0);
            return;
        end
        @(negedge clk);
        // First BUSY cycle.
        alu_done = 1'b0;
        check("alu_start_pulse", alu_start, 1);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("alu_start_single", alu_start, 0);
        end
        alu_done  = 1'b1;
        alu_flags = flags;
        if (wr_done) begin
            sr_wr_en   = 1'b1;
            sr_wr_data = wr_done_d;
        end
        if (fl_mode == 2) begin
            flush = 1'b1;
            if (wr_done) ref_sr = wr_done_d;
            @(negedge clk);
            alu_done = 1'b0;
            flush    = 1'b0;
            sr_wr_en = 1'b0;
            check("kill_after_flush", alu_kill, 1);
            check("flush_no_commit", commit_valid, 0);
            check("flush_sr_kept", sr, ref_sr);
            check("flush_to_idle", issue_ready, 1);
            @(negedge clk);
            check("kill_single", alu_kill, 0);
            return;
        end
        if (s) ref_sr = flags;
        else if (wr_done) ref_sr = wr_done_d;
        ref_pass = ref_pass + 8'd1;
        e = '{pass: 1'b1, sr: ref_sr, pcnt: ref_pass, fcnt: ref_fail};
        sb.push_back(e);
        @(negedge clk);
        alu_done = 1'b0;
        sr_wr_en = 1'b0;
        check("exec_latency", commit_valid, 1);
        check("exec_no_kill", alu_kill, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        issue_valid = 1'b0; alu_done = 1'b0; flush = 1'b0; sr_wr_en = 1'b0;
        repeat (2) @(negedge clk);
        ref_sr = 4'h0; ref_pass = 8'd0; ref_fail = 8'd0;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("reset_ready", issue_ready, 1);
        check("reset_sr", sr, 0);
        check("reset_pass_cnt", pass_cnt, 0);
        check("reset_fail_cnt", fail_cnt, 0);
        check("reset_pulses", {alu_start, alu_kill, commit_valid, commit_pass}, 0);

        // Execute with S=1, ALU done three cycles after start.
        write_sr(4'b0100);
        run_instr(4'd0, 1'b1, 3, 4'b1000, 0, 1'b0, 4'h0, 1'b0, 4'h0);
        check("exec_sr_from_alu", sr, 4'b1000);
        check("exec_pass_cnt", pass_cnt, 1);

        // Skip: NE with Z set.
        write_sr(4'b0100);
        run_instr(4'd1, 1'b0, 0, 4'h0, 0, 1'b0, 4'h0, 1'b0, 4'h0);
        check("skip_sr_kept", sr, 4'b0100);
        check("skip_fail_cnt", fail_cnt, 1);

        // Flush together with alu_done in BUSY.
        run_instr(4'd14, 1'b1, 1, 4'b1111, 2, 1'b0, 4'h0, 1'b0, 4'h0);

        // ALU flag update beats a simultaneous direct write; then direct write alone.
        run_instr(4'd14, 1'b1, 0, 4'b1000, 0, 1'b1, 4'b0011, 1'b0, 4'h0);
        check("alu_beats_write", sr, 4'b1000);
        write_sr(4'b0011);

        // Flush during CHECK.
        run_instr(4'd14, 1'b1, 0, 4'b0001, 1, 1'b0, 4'h0, 1'b0, 4'h0);

        // Randomized instructions.
        for (int i = 0; i < 150; i++) begin
            int r;
            int fm;
            r  = int'($urandom % 8);
            fm = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            if ($urandom % 6 == 0) write_sr(4'($urandom));
            run_instr(4'($urandom), 1'($urandom), int'($urandom % 4), 4'($urandom), fm,
                      ($urandom % 4) == 0, 4'($urandom), ($urandom % 4) == 0, 4'($urandom));
        end

        // Counter wrap with back-to-back skipped instructions (Z clear, cond EQ).
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_instr(4'd0, 1'b0, 0, 4'h0, 0, 1'b0, 4'h0, 1'b0, 4'h0);
            if (i == 254) check("fail_cnt_255", fail_cnt, 255);
        end
        check("fail_cnt_wrap", fail_cnt, 0);

        // Asynchronous reset mid-BUSY, between clock edges.
        write_sr(4'b1111);
        run_instr(4'd14, 1'b0, 0, 4'h0, 0, 1'b0, 4'h0, 1'b0, 4'h0);
        issue_valid = 1'b1; issue_cond = 4'd14; issue_s = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_start", alu_start, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_start", alu_start, 0);
        check("async_rst_sr", sr, 0);
        check("async_rst_ready", issue_ready, 1);
        check("async_rst_cnts", {pass_cnt, fail_cnt}, 0);
        check("async_rst_pulses", {alu_kill, commit_valid, commit_pass}, 0);
        ref_sr = 4'h0; ref_pass = 8'd0; ref_fail = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        alu_done = 1'b1;
        alu_flags = 4'hF;
        repeat (4) @(negedge clk);
        alu_done = 1'b0;
        check("post_reset_no_kill", alu_kill, 0);
        check("post_reset_sr", sr, 0);
        check("post_reset_pass_cnt", pass_cnt, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cond_exec_ctrl.md
COND_EXEC_CTRL -- requirements
Module: cond_exec_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of the pass/fail instruction counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 issue_valid  input  1  instruction offered for conditional execution.
REQ-005 issue_ready  output  1  controller can accept an instruction.
REQ-006 issue_cond  input  4  ARM condition field of offered instruction.
REQ-007 issue_s  input  1  offered instruction updates flags (S bit).
REQ-008 alu_start  output  1  one-cycle pulse launching the ALU operation.
REQ-009 alu_done  input  1  ALU result and flags valid.
REQ-010 alu_flags  input  4  ALU flags {N,Z,C,V}.
REQ-011 alu_kill  output  1  one-cycle pulse aborting the in-flight ALU operation.
REQ-012 flush  input  1  discard the instruction currently held.
REQ-013 sr_wr_en  input  1  direct status-register write (MSR path).
REQ-014 sr_wr_data  input  4  data for direct write, {N,Z,C,V}.
REQ-015 sr  output  4  status register {N,Z,C,V}; bit3 N, bit2 Z, bit1 C, bit0 V.
REQ-016 commit_valid  output  1  one-cycle pulse: held instruction retired.
REQ-017 commit_pass  output  1  retired instruction executed (1) or was skipped (0).
REQ-018 pass_cnt  output  CNT_W  count of executed instructions.
REQ-019 fail_cnt  output  CNT_W  count of skipped instructions.

Function
REQ-020 States SHALL be IDLE, CHECK, BUSY; issue_ready SHALL equal (state==IDLE).
REQ-021 IDLE: issue_valid&issue_ready at an edge SHALL capture issue_cond/issue_s and move to CHECK.
REQ-022 CHECK SHALL evaluate the captured cond against sr: 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V; 8 C&!Z; 9 !C|Z; 10 N==V; 11 N!=V; 12 !Z&(N==V); 13 Z|(N!=V); 14,15 true.
REQ-023 CHECK pass: next state BUSY, alu_start=1 for exactly the first BUSY cycle.
REQ-024 CHECK fail: next state IDLE, commit_valid=1 and commit_pass=0 for one cycle, fail_cnt+1.
REQ-025 BUSY SHALL sample alu_done every cycle including the alu_start cycle; alu_done outside BUSY SHALL be ignored.
REQ-026 BUSY with alu_done: next state IDLE, commit_valid=1 and commit_pass=1 for one cycle, pass_cnt+1, sr<=alu_flags iff captured s=1.
REQ-027 Latency: accept edge to commit_valid = 2 cycles for skip; alu_done edge to commit_valid = 1 cycle for execute.
REQ-028 A new instruction SHALL be acceptable in the same cycle commit_valid is high.
REQ-029 flush in CHECK or BUSY: next state IDLE, no commit, no counter change, sr not updated from ALU; flush in IDLE has no effect.
REQ-030 flush in BUSY SHALL produce alu_kill=1 for the following cycle; flush wins over simultaneous alu_done.
REQ-031 sr_wr_en SHALL load sr_wr_data at the edge in any state; simultaneous ALU flag update (REQ-026) SHALL take priority.
REQ-032 CHECK SHALL use the sr value present during the CHECK cycle (includes any write from the preceding edge).
REQ-033 pass_cnt and fail_cnt SHALL wrap modulo 2^CNT_W.
REQ-034 commit_pass SHALL be 0 whenever commit_valid=0.

Reset
REQ-035 rst_n low SHALL immediately force state IDLE, sr=0000, pass_cnt=fail_cnt=0, alu_start=alu_kill=commit_valid=commit_pass=0, independent of clk.
REQ-036 Reset asserted in CHECK or BUSY SHALL discard the held instruction with no commit and no alu_kill.

Verification
REQ-037 sr=0100, issue cond=0 s=1, alu_done 3 cycles after alu_start with flags 1000 -> alu_start 1 pulse, commit_valid/pass=1 one cycle after alu_done, sr=1000, pass_cnt=1.
REQ-038 sr=0100, issue cond=1 -> no alu_start, commit_valid=1 commit_pass=0 two cycles after accept, fail_cnt=1, sr unchanged.
REQ-039 BUSY with flush and alu_done same cycle, s=1, flags 1111 -> alu_kill next cycle, no commit, sr unchanged, state IDLE.
REQ-040 sr_wr_en with data 0011 on the same edge as alu_done (s=1, flags 1000) -> sr=1000; sr_wr_en alone in IDLE -> sr=0011.
REQ-041 255 skipped instructions then one more (CNT_W=8) -> fail_cnt 255 then 0; back-to-back issue accepted in commit cycle.
REQ-042 rst_n low mid-BUSY between clock edges -> outputs and sr zero immediately, issue_ready=1, no commit after release.
